// File: rtl/perf_counters_if.sv
// Wishbone slave-port bundle for the performance counter unit.
// The master modport is the bus side that issues accesses; the slave
// modport is the counter block that answers them.
interface perf_counters_if #(
   parameter int ADR_W = 8
);
   logic             wb_cyc;
   logic             wb_stb;
   logic             wb_we;
   logic [ADR_W-1:0] wb_adr;
   logic [31:0]      wb_dat_i;
   logic [31:0]      wb_dat_o;
   logic             wb_ack;
   logic             wb_err;
   logic             wb_rty;

   modport master (
      output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i,
      input  wb_dat_o, wb_ack, wb_err, wb_rty
   );

   modport slave (
      input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i,
      output wb_dat_o, wb_ack, wb_err, wb_rty
   );
endinterface

// File: rtl/perf_counters.sv
// Wishbone performance-monitoring unit.
// Passively watches cyc/stb/ack/we of N_MON bus masters and keeps four
// event counters per master (BUSY, RD, WR, WAIT) plus a global cycle
// counter. A 32-bit Wishbone slave port exposes CTRL, STATUS and the
// counters. Counters either wrap or saturate; every overflow sets a
// sticky, write-1-to-clear STATUS bit.
module perf_counters #(
   parameter int N_MON    = 2,
   parameter int CNT_W    = 32,
   parameter bit SATURATE = 1'b0,
   parameter int ADR_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   perf_counters_if.slave   wb,
   input  logic [N_MON-1:0] mon_cyc_i,
   input  logic [N_MON-1:0] mon_stb_i,
   input  logic [N_MON-1:0] mon_ack_i,
   input  logic [N_MON-1:0] mon_we_i
);

   // Counter k of channel c lives at index 4*c + k, with k ordered as in
   // the register map: 0 BUSY, 1 RD, 2 WR, 3 WAIT.
   localparam int N_CNT = 4 * N_MON;
   localparam int WRD_W = ADR_W - 2;   // word address width
   localparam int CH_W  = ADR_W - 4;   // channel-group index width

   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t CNT_ONES = {CNT_W{1'b1}};
   localparam cnt_t CNT_ZERO = {CNT_W{1'b0}};
   localparam cnt_t CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   // Next value of one counter: clear beats counting, and a saturating
   // counter parks at all-ones instead of wrapping.
   function automatic cnt_t cnt_step(input cnt_t cur, input logic inc, input logic clr);
      cnt_t nxt;
      nxt = cur;
      if (clr) begin
         nxt = CNT_ZERO;
      end else if (inc && (cur == CNT_ONES) && SATURATE) begin
         nxt = cur;
      end else if (inc) begin
         nxt = cur + CNT_ONE;
      end else begin
         nxt = cur;
      end
      return nxt;
   endfunction

   // An overflow is any counted event that finds the counter at all-ones.
   function automatic logic cnt_ovf(input cnt_t cur, input logic inc);
      return inc & (cur == CNT_ONES);
   endfunction

   // Zero-extend a counter to bus width.
   function automatic logic [31:0] zext_cnt(input cnt_t v);
      logic [31:0] r;
      r             = 32'd0;
      r[CNT_W-1:0]  = v;
      return r;
   endfunction

   // Zero-extend the STATUS vector to bus width.
   function automatic logic [31:0] zext_status(input logic [N_MON:0] v);
      logic [31:0] r;
      r            = 32'd0;
      r[N_MON:0]   = v;
      return r;
   endfunction

   // ---------------------------------------------------------------
   // State
   // ---------------------------------------------------------------
   logic             ack_q, ack_d;
   logic [31:0]      dat_q, dat_d;
   logic             en_q, en_d;
   logic [N_MON:0]   status_q, status_d;
   cnt_t             gcyc_q, gcyc_d;
   cnt_t             cnt_q [N_CNT];
   cnt_t             cnt_d [N_CNT];

   // ---------------------------------------------------------------
   // Combinational nets
   // ---------------------------------------------------------------
   logic             req_s;
   logic             wr_s;
   logic [WRD_W-1:0] word_s;
   logic [CH_W-1:0]  grp_s;
   logic [CH_W-1:0]  ch_s;
   logic [1:0]       reg_s;
   logic             in_chan_s;
   logic [N_MON-1:0] chan_hit_s;
   logic             ctrl_wr_s;
   logic             status_wr_s;
   logic             clr_s;
   logic [N_CNT-1:0] ev_s;
   logic [N_CNT-1:0] ovf_s;
   logic             gcyc_ovf_s;
   logic [31:0]      rd_data_s;
   logic             unused_s;

   // A new request is accepted only when no ack is pending, so each
   // access yields exactly one ack cycle.
   assign req_s = wb.wb_cyc & wb.wb_stb & ~ack_q;
   assign wr_s  = req_s & wb.wb_we;

   // Byte lanes are not decoded and only the low STATUS/CTRL bits matter.
   assign unused_s = ^{wb.wb_adr[1:0], wb.wb_dat_i};

   // Address decode: words 0..2 are CTRL/STATUS/GCYC, and each group of
   // four words from word 4 upward is one monitor channel.
   always_comb begin
      word_s     = wb.wb_adr[ADR_W-1:2];
      grp_s      = word_s[WRD_W-1:2];
      reg_s      = word_s[1:0];
      in_chan_s  = (grp_s != CH_W'(0));
      ch_s       = grp_s - CH_W'(1);
      chan_hit_s = {N_MON{1'b0}};
      for (int c = 0; c < N_MON; c++) begin
         chan_hit_s[c] = in_chan_s & (ch_s == CH_W'(c));
      end
      ctrl_wr_s   = wr_s & (word_s == WRD_W'(0));
      status_wr_s = wr_s & (word_s == WRD_W'(1));
      clr_s       = ctrl_wr_s & wb.wb_dat_i[1];
   end

   // Read multiplexer: unmapped words, including channels beyond N_MON,
   // fall through to zero.
   always_comb begin
      rd_data_s = 32'd0;
      case (word_s)
         WRD_W'(0): rd_data_s[0] = en_q;
         WRD_W'(1): rd_data_s    = zext_status(status_q);
         WRD_W'(2): rd_data_s    = zext_cnt(gcyc_q);
         default: begin
            for (int c = 0; c < N_MON; c++) begin
               rd_data_s = rd_data_s |
                           (chan_hit_s[c] ? zext_cnt(cnt_q[4*c + int'(reg_s)]) : 32'd0);
            end
         end
      endcase
   end

   // Bus response: ack one cycle after the request is sampled, with the
   // register value from that same cycle; data is zero whenever ack is low.
   always_comb begin
      ack_d = req_s;
      if (req_s && !wb.wb_we) begin
         dat_d = rd_data_s;
      end else begin
         dat_d = 32'd0;
      end
   end

   // Classify the monitored bus activity of every channel this cycle.
   always_comb begin
      ev_s = {N_CNT{1'b0}};
      for (int c = 0; c < N_MON; c++) begin
         ev_s[4*c + 0] = mon_cyc_i[c];
         ev_s[4*c + 1] = mon_cyc_i[c] & mon_stb_i[c] &  mon_ack_i[c] & ~mon_we_i[c];
         ev_s[4*c + 2] = mon_cyc_i[c] & mon_stb_i[c] &  mon_ack_i[c] &  mon_we_i[c];
         ev_s[4*c + 3] = mon_cyc_i[c] & mon_stb_i[c] & ~mon_ack_i[c];
      end
   end

   // Counter next-state: counting follows the enable already in force, so
   // a CTRL write changes counting only from the following cycle.
   always_comb begin
      for (int k = 0; k < N_CNT; k++) begin
         cnt_d[k] = cnt_step(cnt_q[k], en_q & ev_s[k], clr_s);
         ovf_s[k] = cnt_ovf(cnt_q[k], en_q & ev_s[k]);
      end
      gcyc_d     = cnt_step(gcyc_q, en_q, clr_s);
      gcyc_ovf_s = cnt_ovf(gcyc_q, en_q);
   end

   // Control next-state: en follows a CTRL write; STATUS bits are sticky,
   // cleared by writing 1, and a same-cycle overflow wins over the clear.
   always_comb begin
      if (ctrl_wr_s) begin
         en_d = wb.wb_dat_i[0];
      end else begin
         en_d = en_q;
      end
      status_d = status_q;
      for (int c = 0; c < N_MON; c++) begin
         status_d[c] = (status_q[c] & ~(status_wr_s & wb.wb_dat_i[c])) |
                       (|ovf_s[4*c +: 4]);
      end
      status_d[N_MON] = (status_q[N_MON] & ~(status_wr_s & wb.wb_dat_i[N_MON])) |
                        gcyc_ovf_s;
   end

   // Slave handshake registers; reset drops ack immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_q <= 1'b0;
         dat_q <= 32'd0;
      end else begin
         ack_q <= ack_d;
         dat_q <= dat_d;
      end
   end

   // Enable and overflow status registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_q     <= 1'b0;
         status_q <= {(N_MON+1){1'b0}};
      end else begin
         en_q     <= en_d;
         status_q <= status_d;
      end
   end

   // Event and global cycle counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gcyc_q <= CNT_ZERO;
         for (int k = 0; k < N_CNT; k++) begin
            cnt_q[k] <= CNT_ZERO;
         end
      end else begin
         gcyc_q <= gcyc_d;
         for (int k = 0; k < N_CNT; k++) begin
            cnt_q[k] <= cnt_d[k];
         end
      end
   end

   assign wb.wb_ack   = ack_q;
   assign wb.wb_dat_o = dat_q;
   assign wb.wb_err   = 1'b0;
   assign wb.wb_rty   = 1'b0;

endmodule

// File: tb/tb_perf_counters.sv
// Bench for perf_counters: three instances share the monitor inputs.
//   u0: N_MON=2, CNT_W=32, wrapping
//   u1: N_MON=2, CNT_W=8,  wrapping
//   u2: N_MON=2, CNT_W=8,  saturating
// Expected read data is queued when an access is issued and compared
// when the ack arrives.
module tb_perf_counters;

   logic        clk;
   logic        rst;
   logic [1:0]  m_cyc, m_stb, m_ack, m_we;

   logic        b_cyc, b_stb, b_we;
   logic [7:0]  b_adr;
   logic [31:0] b_dat;
   int          bsel;

   logic        s_ack;
   logic [31:0] s_dat;

   int          n_chk;
   int          n_err;

   logic [31:0] exp_q[$];
   string       tag_q[$];

   perf_counters_if #(.ADR_W(8)) bus0();
   perf_counters_if #(.ADR_W(8)) bus1();
   perf_counters_if #(.ADR_W(8)) bus2();

   assign bus0.wb_cyc = b_cyc & (bsel == 0);
   assign bus0.wb_stb = b_stb & (bsel == 0);
   assign bus1.wb_cyc = b_cyc & (bsel == 1);
   assign bus1.wb_stb = b_stb & (bsel == 1);
   assign bus2.wb_cyc = b_cyc & (bsel == 2);
   assign bus2.wb_stb = b_stb & (bsel == 2);
   assign bus0.wb_we = b_we;   assign bus1.wb_we = b_we;   assign bus2.wb_we = b_we;
   assign bus0.wb_adr = b_adr; assign bus1.wb_adr = b_adr; assign bus2.wb_adr = b_adr;
   assign bus0.wb_dat_i = b_dat; assign bus1.wb_dat_i = b_dat; assign bus2.wb_dat_i = b_dat;

   assign s_ack = (bsel == 0) ? bus0.wb_ack : ((bsel == 1) ? bus1.wb_ack : bus2.wb_ack);
   assign s_dat = (bsel == 0) ? bus0.wb_dat_o : ((bsel == 1) ? bus1.wb_dat_o : bus2.wb_dat_o);

   perf_counters #(.N_MON(2), .CNT_W(32), .SATURATE(1'b0), .ADR_W(8)) u0 (
      .clk(clk), .rst(rst), .wb(bus0),
      .mon_cyc_i(m_cyc), .mon_stb_i(m_stb), .mon_ack_i(m_ack), .mon_we_i(m_we)
   );
   perf_counters #(.N_MON(2), .CNT_W(8), .SATURATE(1'b0), .ADR_W(8)) u1 (
      .clk(clk), .rst(rst), .wb(bus1),
      .mon_cyc_i(m_cyc), .mon_stb_i(m_stb), .mon_ack_i(m_ack), .mon_we_i(m_we)
   );
   perf_counters #(.N_MON(2), .CNT_W(8), .SATURATE(1'b1), .ADR_W(8)) u2 (
      .clk(clk), .rst(rst), .wb(bus2),
      .mon_cyc_i(m_cyc), .mon_stb_i(m_stb), .mon_ack_i(m_ack), .mon_we_i(m_we)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop if the sequence ever stalls.
   initial begin
      #400000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
      end
   endtask

   // One bus access, started at a falling edge; returns the time of the
   // falling edge at which ack was seen, and ends one cycle later.
   task automatic xfer(input int sel, input bit we, input logic [7:0] adr,
                       input logic [31:0] wdat, input logic [31:0] rexp,
                       input string tag, output longint t_ack);
      int          waited;
      bit          got;
      logic [31:0] e;
      string       tg;
      bsel  = sel;
      b_cyc = 1'b1;
      b_stb = 1'b1;
      b_we  = we;
      b_adr = adr;
      b_dat = wdat;
      if (!we) begin
         exp_q.push_back(rexp);
         tag_q.push_back(tag);
      end
      waited = 0;
      got    = 1'b0;
      while (!got && waited < 8) begin
         @(negedge clk);
         waited++;
         if (s_ack) got = 1'b1;
      end
      t_ack = $time;
      chk({tag, ":ack"}, {31'd0, got}, 32'd1);
      if (!we) begin
         e  = exp_q.pop_front();
         tg = tag_q.pop_front();
         chk(tg, s_dat, e);
      end
      b_cyc = 1'b0;
      b_stb = 1'b0;
      b_we  = 1'b0;
      @(negedge clk);
      chk({tag, ":ack_once"}, {31'd0, s_ack}, 32'd0);
   endtask

   task automatic rd(input int sel, input logic [7:0] adr, input logic [31:0] exp, input string tag);
      longint t;
      xfer(sel, 1'b0, adr, 32'd0, exp, tag, t);
   endtask

   task automatic wr(input int sel, input logic [7:0] adr, input logic [31:0] dat,
                     input string tag, output longint t);
      xfer(sel, 1'b1, adr, dat, 32'd0, tag, t);
   endtask

   initial begin
      longint      t_en, t_dis, t_x;
      longint      n;
      logic [31:0] e;
      n_chk = 0;
      n_err = 0;
      rst   = 1'b1;
      bsel  = 0;
      b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0; b_adr = 8'h00; b_dat = 32'd0;
      m_cyc = 2'b11; m_stb = 2'b11; m_ack = 2'b01; m_we = 2'b10;

      // Reset with monitor and bus inputs active.
      repeat (2) @(negedge clk);
      b_cyc = 1'b1; b_stb = 1'b1; b_adr = 8'h08;
      @(negedge clk);
      chk("rst_ack", {31'd0, s_ack}, 32'd0);
      chk("rst_dat", s_dat, 32'd0);
      chk("err_rty", {30'd0, bus0.wb_err, bus0.wb_rty}, 32'd0);
      b_cyc = 1'b0; b_stb = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // Everything reads zero and stays zero while disabled (monitors busy).
      rd(0, 8'h00, 32'd0, "r_ctrl");
      rd(0, 8'h04, 32'd0, "r_status");
      rd(0, 8'h08, 32'd0, "r_gcyc");
      for (int i = 0; i < 8; i++) rd(0, 8'(8'h10 + 4 * i), 32'd0, $sformatf("r_cnt%0d", i));
      rd(1, 8'h10, 32'd0, "r_u1_busy0");
      rd(2, 8'h08, 32'd0, "r_u2_gcyc");
      m_cyc = 2'b00; m_stb = 2'b00; m_ack = 2'b00; m_we = 2'b00;

      // Main event pattern on channel 0 of u0.
      wr(0, 8'h00, 32'd1, "en_on", t_en);
      m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
      repeat (3) @(negedge clk);
      m_ack[0] = 1'b1;
      @(negedge clk);
      m_stb[0] = 1'b0; m_ack[0] = 1'b0;
      repeat (2) @(negedge clk);
      m_stb[0] = 1'b1; m_ack[0] = 1'b1; m_we[0] = 1'b1;
      @(negedge clk);
      m_cyc = 2'b00; m_stb = 2'b00; m_ack = 2'b00; m_we = 2'b00;
      wr(0, 8'h00, 32'd0, "en_off", t_dis);
      rd(0, 8'h10, 32'd7, "busy0");
      rd(0, 8'h14, 32'd1, "rd0");
      rd(0, 8'h18, 32'd1, "wr0");
      rd(0, 8'h1C, 32'd3, "wait0");
      for (int i = 0; i < 4; i++) rd(0, 8'(8'h20 + 4 * i), 32'd0, $sformatf("ch1_%0d", i));
      rd(0, 8'h08, 32'((t_dis - t_en) / 10), "gcyc");

      // Decode edge cases on u0.
      rd(0, 8'h30, 32'd0, "unmap_ch2");
      rd(0, 8'h0C, 32'd0, "unmap_0c");
      rd(0, 8'h04, 32'd0, "status0");
      wr(0, 8'h10, 32'hFFFF_FFFF, "wr_ro_busy", t_x);
      rd(0, 8'h10, 32'd7, "busy0_kept");
      wr(0, 8'h08, 32'h0000_1234, "wr_ro_gcyc", t_x);
      rd(0, 8'h08, 32'((t_dis - t_en) / 10), "gcyc_kept");
      wr(0, 8'h30, 32'h0000_0003, "wr_unmap", t_x);
      rd(0, 8'h00, 32'd0, "ctrl_kept");

      // 8-bit wrapping counters on u1.
      wr(1, 8'h00, 32'd1, "u1_en", t_en);
      m_cyc[0] = 1'b1;
      repeat (258) @(negedge clk);
      m_cyc[0] = 1'b0;
      wr(1, 8'h00, 32'd0, "u1_dis", t_dis);
      n = (t_dis - t_en) / 10;
      rd(1, 8'h10, 32'd2, "u1_busy0");
      rd(1, 8'h1C, 32'd0, "u1_wait0");
      rd(1, 8'h08, 32'(n % 256), "u1_gcyc");
      e = (n > 255) ? 32'd5 : 32'd1;
      rd(1, 8'h04, e, "u1_status");
      wr(1, 8'h04, 32'd1, "u1_w1c", t_x);
      rd(1, 8'h04, e & 32'hFFFF_FFFE, "u1_status_clr");
      wr(1, 8'h04, 32'd0, "u1_w0", t_x);
      rd(1, 8'h04, e & 32'hFFFF_FFFE, "u1_status_w0");
      wr(1, 8'h04, 32'd4, "u1_w1c_g", t_x);
      rd(1, 8'h04, 32'd0, "u1_status_0");
      rd(1, 8'h10, 32'd2, "u1_busy0_kept");

      // 8-bit saturating counters on u2.
      wr(2, 8'h00, 32'd1, "u2_en", t_en);
      m_cyc[0] = 1'b1;
      repeat (258) @(negedge clk);
      rd(2, 8'h10, 32'd255, "u2_busy0");
      repeat (10) @(negedge clk);
      rd(2, 8'h10, 32'd255, "u2_busy0_hold");
      rd(2, 8'h08, 32'd255, "u2_gcyc");
      m_cyc[0] = 1'b0;
      wr(2, 8'h00, 32'd0, "u2_dis", t_x);
      rd(2, 8'h04, 32'd5, "u2_status");
      rd(2, 8'h20, 32'd0, "u2_busy1");

      // Clear while channel 0 is active on u0.
      wr(0, 8'h00, 32'd1, "c_en", t_x);
      m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
      repeat (4) @(negedge clk);
      wr(0, 8'h00, 32'd3, "c_clr", t_en);
      m_cyc = 2'b00; m_stb = 2'b00;
      rd(0, 8'h00, 32'd1, "c_ctrl");
      wr(0, 8'h00, 32'd0, "c_dis", t_dis);
      rd(0, 8'h10, 32'd1, "c_busy0");
      rd(0, 8'h14, 32'd0, "c_rd0");
      rd(0, 8'h18, 32'd0, "c_wr0");
      rd(0, 8'h1C, 32'd1, "c_wait0");
      rd(0, 8'h08, 32'((t_dis - t_en) / 10), "c_gcyc");
      rd(0, 8'h04, 32'd0, "c_status");

      // Reset in the middle of an access while counting.
      wr(0, 8'h00, 32'd1, "m_en", t_x);
      m_cyc[0] = 1'b1;
      repeat (3) @(negedge clk);
      bsel = 0; b_cyc = 1'b1; b_stb = 1'b1; b_we = 1'b0; b_adr = 8'h10;
      @(posedge clk);
      #2;
      chk("m_ack_pre", {31'd0, s_ack}, 32'd1);
      rst = 1'b1;
      #1;
      chk("m_ack_rst", {31'd0, s_ack}, 32'd0);
      chk("m_dat_rst", s_dat, 32'd0);
      @(negedge clk);
      b_cyc = 1'b0; b_stb = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rd(0, 8'h00, 32'd0, "m_ctrl");
      rd(0, 8'h10, 32'd0, "m_busy0");
      rd(0, 8'h08, 32'd0, "m_gcyc");
      m_cyc = 2'b00;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
